// File: rtl/mdu_pkg.sv
// Shared types, constants and helpers for the RV32M multiply/divide sequencer.
package mdu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Funct3 encodings of the M-extension operations
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == MDU_MUL) || (f3 == MDU_MULH) || (f3 == MDU_MULHSU) ||
           (f3 == MDU_DIV) || (f3 == MDU_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV and REM
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == MDU_MUL) || (f3 == MDU_MULH) ||
           (f3 == MDU_DIV) || (f3 == MDU_REM);
  endfunction

  // Two's-complement negate; 32-bit users zero-extend and truncate the result
  function automatic logic [2*XLEN-1:0] twos_neg(input logic [2*XLEN-1:0] v);
    return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/mul_div_sequencer.sv
// Multi-cycle RV32M sequencer: 32-step shift-add multiply / restoring divide
// on operand magnitudes, followed by one sign-correction cycle.
module mul_div_sequencer
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  mdu_state_e        r_state;
  mdu_state_e        w_state_next;
  logic              w_accept;

  logic [4:0]        r_count;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_a_mag;
  logic [XLEN-1:0]   r_b_mag;
  logic [XLEN-1:0]   r_a_orig;
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_div0;
  logic              r_ovf;
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_result;

  // operand sign/magnitude at acceptance
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_ovf;

  assign w_sa    = is_signed_a(Funct3) & operand_a[XLEN-1];
  assign w_sb    = is_signed_b(Funct3) & operand_b[XLEN-1];
  assign w_a_mag = w_sa ? XLEN'(twos_neg({{XLEN{1'b0}}, operand_a})) : operand_a;
  assign w_b_mag = w_sb ? XLEN'(twos_neg({{XLEN{1'b0}}, operand_b})) : operand_b;
  assign w_ovf   = ((Funct3 == MDU_DIV) || (Funct3 == MDU_REM)) &&
                   (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (operand_b == {XLEN{1'b1}});

  // multiply step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole product right by one
  logic [XLEN-1:0]   w_addend;
  logic [XLEN:0]     w_sum;

  assign w_addend = r_prod[0] ? r_a_mag : '0;
  assign w_sum    = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, w_addend};

  // divide step: bring in the next dividend bit, subtract if it fits
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_sub;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b_mag});
  assign w_sub   = w_shift[XLEN-1:0] - r_b_mag;

  // sign correction and result selection
  logic              w_neg_res;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_result;

  assign w_neg_res  = r_sign_a ^ r_sign_b;
  assign w_prod_fix = w_neg_res ? twos_neg(r_prod) : r_prod;
  assign w_quo_fix  = w_neg_res ? XLEN'(twos_neg({{XLEN{1'b0}}, r_quo})) : r_quo;
  assign w_rem_fix  = r_sign_a  ? XLEN'(twos_neg({{XLEN{1'b0}}, r_rem})) : r_rem;

  // pick the architectural result, overriding divide special cases
  always_comb begin
    w_fix_result = '0;
    case (r_op)
      MDU_MUL:                        w_fix_result = w_prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU: begin
        if (r_div0)     w_fix_result = {XLEN{1'b1}};
        else if (r_ovf) w_fix_result = {1'b1, {(XLEN-1){1'b0}}};
        else            w_fix_result = w_quo_fix;
      end
      default: begin
        if (r_div0)     w_fix_result = r_a_orig;
        else if (r_ovf) w_fix_result = '0;
        else            w_fix_result = w_rem_fix;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // next-state, acceptance and handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    stall        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        stall = start;
        if (start && !kill) begin
          w_accept     = 1'b1;
          w_state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (kill)                 w_state_next = ST_IDLE;
        else if (r_count == 5'd31) w_state_next = ST_FIX;
      end
      ST_FIX: begin
        busy  = 1'b1;
        stall = 1'b1;
        if (kill) w_state_next = ST_IDLE;
        else      w_state_next = ST_DONE;
      end
      default: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // datapath: latch on acceptance, iterate in CALC, register result in FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_op     <= '0;
      r_a_mag  <= '0;
      r_b_mag  <= '0;
      r_a_orig <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_count  <= '0;
      r_op     <= Funct3;
      r_a_mag  <= w_a_mag;
      r_b_mag  <= w_b_mag;
      r_a_orig <= operand_a;
      r_sign_a <= w_sa;
      r_sign_b <= w_sb;
      r_div0   <= (operand_b == '0);
      r_ovf    <= w_ovf;
      r_prod   <= {{XLEN{1'b0}}, w_b_mag};
      r_rem    <= '0;
      r_quo    <= w_a_mag;
    end else if (r_state == ST_CALC) begin
      r_count <= r_count + 5'd1;
      if (r_op[2]) begin
        r_rem <= w_ge ? w_sub : w_shift[XLEN-1:0];
        r_quo <= {r_quo[XLEN-2:0], w_ge};
      end else begin
        r_prod <= {w_sum, r_prod[XLEN-1:1]};
      end
    end else if ((r_state == ST_FIX) && !kill) begin
      r_result <= w_fix_result;
    end
  end

  assign result = r_result;

endmodule
